// File: rtl/circuit_pkg.sv
// circuit_pkg: shared pair type, default width and majority helper for io_pair_circuit.
package circuit_pkg;

    localparam int T_IO_PAIRS_DEF = 2;

    // {b,a} on the input side, {c,s} on the output side
    typedef struct packed {
        logic hi;
        logic lo;
    } pair_t;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/io_pair_circuit_fa_cell.sv
// fa_cell: combinational 1-bit full adder cell.
module fa_cell
    import circuit_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = maj3(a, b, ci);

endmodule

// File: rtl/io_pair_circuit.sv
// io_pair_circuit: ripple chain of full-adder cells over 2-bit input pairs, registered output.
// CIRCUIT_PIPE_EN: one register stage per cell, latency T_IO_PAIRS, one result per cycle.
module io_pair_circuit
    import circuit_pkg::*;
#(
    parameter int T_IO_PAIRS = T_IO_PAIRS_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [2*T_IO_PAIRS-1:0] in,
    output logic                    out_valid,
    output logic [2*T_IO_PAIRS-1:0] out
);

    localparam int W = 2 * T_IO_PAIRS;

`ifdef CIRCUIT_PIPE_EN
    logic [W-1:0] dq [T_IO_PAIRS];
    logic [W-1:0] oq [T_IO_PAIRS];
    logic         cq [T_IO_PAIRS];
    logic         vq [T_IO_PAIRS];

    // stage k owns cell k; the full input word and partial result travel alongside
    for (genvar k = 0; k < T_IO_PAIRS; k++) begin : g_stage
        logic [W-1:0] din, oin;
        logic         ci, vin, s, co;
        pair_t        p;
        if (k == 0) begin : g_head
            assign din = in;
            assign oin = '0;
            assign ci  = 1'b0;
            assign vin = in_valid;
        end else begin : g_link
            assign din = dq[k-1];
            assign oin = oq[k-1];
            assign ci  = cq[k-1];
            assign vin = vq[k-1];
        end
        assign p = din[2*k +: 2];
        fa_cell u_fa (.a(p.lo), .b(p.hi), .ci(ci), .s(s), .co(co));
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vq[k] <= 1'b0;
                cq[k] <= 1'b0;
                dq[k] <= '0;
                oq[k] <= '0;
            end else begin
                vq[k] <= vin;
                if (vin) begin
                    cq[k] <= co;
                    dq[k] <= din;
                    oq[k] <= oin;
                    oq[k][2*k +: 2] <= {co, s};
                end
            end
        end
    end

    assign out       = oq[T_IO_PAIRS-1];
    assign out_valid = vq[T_IO_PAIRS-1];
`else
    logic [T_IO_PAIRS:0] c;
    logic [W-1:0]        res;

    assign c[0] = 1'b0;

    for (genvar k = 0; k < T_IO_PAIRS; k++) begin : g_cell
        pair_t p;
        logic  s;
        assign p = in[2*k +: 2];
        fa_cell u_fa (.a(p.lo), .b(p.hi), .ci(c[k]), .s(s), .co(c[k+1]));
        assign res[2*k +: 2] = {c[k+1], s};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) out <= res;
        end
    end
`endif

endmodule

// File: tb/tb_io_pair_circuit.sv
// tb_io_pair_circuit: scoreboard bench for io_pair_circuit at T_IO_PAIRS=2 and 4.
module tb_io_pair_circuit;

`ifdef CIRCUIT_PIPE_EN
    localparam int L2 = 2;
    localparam int L4 = 4;
`else
    localparam int L2 = 1;
    localparam int L4 = 1;
`endif
    localparam int T_ITERATIONS = 16;

    typedef struct {
        logic [7:0] val;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       v2 = 1'b0, v4 = 1'b0;
    logic [3:0] i2 = '0;
    logic [7:0] i4 = '0;
    logic       ov2, ov4;
    logic [3:0] o2;
    logic [7:0] o4;

    int   checks = 0, errors = 0, cyc = 0;
    exp_t q2[$], q4[$];
    logic [3:0] last2 = '0;
    logic [7:0] last4 = '0;

    io_pair_circuit #(.T_IO_PAIRS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in(i2), .out_valid(ov2), .out(o2)
    );
    io_pair_circuit #(.T_IO_PAIRS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in(i4), .out_valid(ov4), .out(o4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // monitor: pops on out_valid, otherwise requires the last result to hold
    always @(negedge clk) begin
        if (!rst_n) begin
            last2 = '0;
            last4 = '0;
        end else begin
            if (ov2) begin
                if (q2.size() == 0) check("dut2 unexpected out_valid", {28'd0, o2}, 32'hDEAD);
                else begin
                    exp_t e;
                    e = q2.pop_front();
                    check("dut2 out", {28'd0, o2}, {24'd0, e.val});
                    check("dut2 latency", cyc - e.cyc, L2);
                end
                last2 = o2;
            end else check("dut2 hold", {28'd0, o2}, {28'd0, last2});
            if (ov4) begin
                if (q4.size() == 0) check("dut4 unexpected out_valid", {24'd0, o4}, 32'hDEAD);
                else begin
                    exp_t e;
                    e = q4.pop_front();
                    check("dut4 out", {24'd0, o4}, {24'd0, e.val});
                    check("dut4 latency", cyc - e.cyc, L4);
                end
                last4 = o4;
            end else check("dut4 hold", {24'd0, o4}, {24'd0, last4});
        end
    end

    task automatic drive(input logic a_v, input logic [3:0] a_i, input logic [3:0] a_e,
                         input logic b_v, input logic [7:0] b_i, input logic [7:0] b_e);
        @(posedge clk);
        #2;
        v2 = a_v;
        i2 = a_i;
        v4 = b_v;
        i4 = b_i;
        if (a_v) q2.push_back('{val: {4'd0, a_e}, cyc: cyc});
        if (b_v) q4.push_back('{val: b_e, cyc: cyc});
    endtask

    logic [3:0] sweep_exp [16] = '{4'd0, 4'd1, 4'd1, 4'd6, 4'd4, 4'd5, 4'd5, 4'd10,
                                   4'd4, 4'd5, 4'd5, 4'd10, 4'd8, 4'd9, 4'd9, 4'd14};
    logic [7:0] v4_in  [5] = '{8'h00, 8'hFF, 8'h03, 8'hA5, 8'h0F};
    logic [7:0] v4_exp [5] = '{8'h00, 8'hFE, 8'h06, 8'h55, 8'h1E};

    initial begin
        #1 rst_n = 1'b0;
        #2;
        check("reset out2", {28'd0, o2}, 32'd0);
        check("reset valid2", {31'd0, ov2}, 32'd0);
        check("reset out4", {24'd0, o4}, 32'd0);
        check("reset valid4", {31'd0, ov4}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < T_ITERATIONS; i++)
            drive(1'b1, i[3:0], sweep_exp[i], i < 5, i < 5 ? v4_in[i] : 8'h00,
                  i < 5 ? v4_exp[i] : 8'h00);
        drive(1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 8'h00);

        // hold: out must stay 6 while in_valid is low
        drive(1'b1, 4'd3, 4'd6, 1'b0, 8'h00, 8'h00);
        repeat (3) drive(1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 4'd5, 4'd5, 1'b1, 8'h03, 8'h06);
        drive(1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 8'h00);
        repeat (5) @(posedge clk);

        // asynchronous reset mid-stream
        drive(1'b1, 4'd15, 4'd14, 1'b1, 8'hFF, 8'hFE);
        drive(1'b1, 4'd7, 4'd10, 1'b1, 8'h0F, 8'h1E);
        #1;
        rst_n = 1'b0;
        v2 = 1'b0;
        v4 = 1'b0;
        q2.delete();
        q4.delete();
        #1;
        check("midreset out2", {28'd0, o2}, 32'd0);
        check("midreset valid2", {31'd0, ov2}, 32'd0);
        check("midreset out4", {24'd0, o4}, 32'd0);
        check("midreset valid4", {31'd0, ov4}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        drive(1'b1, 4'd3, 4'd6, 1'b1, 8'h03, 8'h06);
        drive(1'b1, 4'd15, 4'd14, 1'b1, 8'hFF, 8'hFE);
        drive(1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 8'h00);

        for (int k = 0; k < 20 && (q2.size() != 0 || q4.size() != 0); k++) @(posedge clk);
        @(negedge clk);
        check("drain q2 empty", q2.size(), 0);
        check("drain q4 empty", q4.size(), 0);
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
